// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-control UART command protocol.
// Used by the host initiator (sys_ctrl_host) and by the remote responder.
package sys_ctrl_pkg;

    // Command opcodes carried in the first byte of every request
    localparam logic [7:0] OP_HALT        = 8'h00;
    localparam logic [7:0] OP_RESUME      = 8'h01;
    localparam logic [7:0] OP_WRITE       = 8'h02;
    localparam logic [7:0] OP_READ        = 8'h03;
    localparam logic [7:0] OP_RESET       = 8'h04;
    localparam logic [7:0] OP_PING        = 8'h05;
    localparam logic [7:0] OP_HOLD_RST    = 8'h06;
    localparam logic [7:0] OP_RELEASE_RST = 8'h07;

    // Responder acknowledge byte for commands that return no data
    localparam logic [7:0] ACK_OK = 8'h00;

    // Response error codes reported on rsp_err
    localparam logic [1:0] ERR_OK         = 2'd0;
    localparam logic [1:0] ERR_BAD_ACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'd3;

    // Host initiator FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TXWAIT_LO,
        ST_TXWAIT_HI,
        ST_RXWAIT,
        ST_RESP
    } host_state_e;

    // An opcode is legal when it falls inside the defined command range
    function automatic logic op_is_legal(input logic [7:0] op);
        return (op <= OP_RELEASE_RST);
    endfunction

    // Index of the final byte of a request: WRITE sends 4, READ 3, others 1
    function automatic logic [1:0] last_byte_idx(input logic [7:0] op);
        logic [1:0] idx;
        case (op)
            OP_WRITE: idx = 2'd3;
            OP_READ:  idx = 2'd2;
            default:  idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sys_ctrl_host.sv
// Host-side initiator for the system-control UART command protocol.
// Serialises one command at a time to a byte UART transmitter, then waits for
// the single response byte and returns it on a one-cycle strobe.
// Optional feature macro: SYS_CTRL_HOST_TIMEOUT_EN compiles in the response
// timeout counter and the rsp_err=2 path; without it RXWAIT waits forever.
module sys_ctrl_host
    import sys_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    host_state_e state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  idx_q, idx_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [7:0]  cur_byte;

`ifdef SYS_CTRL_HOST_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    // Byte mux: selects the outgoing byte for the current position in the request
    always_comb begin
        cur_byte = op_q;
        case (idx_q)
            2'd0: cur_byte = op_q;
            2'd1: cur_byte = addr_q[15:8];
            2'd2: cur_byte = addr_q[7:0];
            2'd3: cur_byte = data_q;
            default: cur_byte = op_q;
        endcase
    end

    // Next-state logic: command latch, byte sequencing, response capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef SYS_CTRL_HOST_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    idx_d  = 2'd0;
                    if (op_is_legal(cmd_op)) begin
                        state_d = ST_LOAD;
                    end else begin
                        rsp_err_d  = ERR_ILLEGAL_OP;
                        rsp_data_d = 8'h00;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_LOAD: begin
                if (tx_done) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    state_d    = ST_TXWAIT_LO;
                end
            end
            ST_TXWAIT_LO: begin
                if (!tx_done) begin
                    state_d = ST_TXWAIT_HI;
                end
            end
            ST_TXWAIT_HI: begin
                if (tx_done) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == last_byte_idx(op_q)) begin
`ifdef SYS_CTRL_HOST_TIMEOUT_EN
                        timer_d = '0;
`endif
                        state_d = ST_RXWAIT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_RXWAIT: begin
                if (rx_valid) begin
                    rsp_data_d = rx_data;
                    if (op_q == OP_READ || rx_data == ACK_OK) begin
                        rsp_err_d = ERR_OK;
                    end else begin
                        rsp_err_d = ERR_BAD_ACK;
                    end
                    state_d = ST_RESP;
                end
`ifdef SYS_CTRL_HOST_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    rsp_data_d = 8'h00;
                    rsp_err_d  = ERR_TIMEOUT;
                    state_d    = ST_RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 8'h00;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            idx_q      <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= ERR_OK;
`ifdef SYS_CTRL_HOST_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef SYS_CTRL_HOST_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sys_ctrl_host.sv
// Self-checking bench for sys_ctrl_host: directed commands, a transmitter and
// responder model, and a per-cycle compare process against expectation queues.
// The timeout scenario runs only when SYS_CTRL_HOST_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_sys_ctrl_host;
    import sys_ctrl_pkg::*;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;

    sys_ctrl_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
        int         at;
        bit         chk_data;
    } rsp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_bytes[$];
    rsp_t       exp_rsp[$];
    logic [7:0] sent_log[$];

    bit         model_busy = 1'b0;
    logic [7:0] held_data  = 8'h00;
    logic [1:0] held_err   = 2'd0;
    bit         held_chk   = 1'b1;
    int         last_rise  = 0;
    int         tx_cnt     = 0;
    logic [7:0] last_rsp_data = 8'h00;
    logic [1:0] last_rsp_err  = 2'd0;
    int         rsp_count  = 0;
    bit         prev_tx_start  = 1'b0;
    bit         prev_rsp_valid = 1'b0;

    // Cycle counter used to time responses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=missing-or-unexpected required=expected-event", name);
    endtask

    // Byte transmitter model: goes busy for three cycles after each start
    always @(negedge clk) begin
        if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) begin
                tx_done   = 1'b1;
                last_rise = cyc;
            end
        end else if (tx_start) begin
            tx_done = 1'b0;
            tx_cnt  = 3;
            sent_log.push_back(tx_data);
        end
    end

    // Compare process: checks DUT outputs against the expectation model each cycle
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, !model_busy});
            checkOutput("busy", {31'd0, busy}, {31'd0, model_busy});
            if (tx_start) begin
                checkOutput("tx_start_width", {31'd0, prev_tx_start}, 32'd0);
                if (exp_bytes.size() == 0) failNow("tx_unexpected");
                else checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
            end
            if (rsp_valid) begin
                checkOutput("rsp_width", {31'd0, prev_rsp_valid}, 32'd0);
                if (exp_rsp.size() == 0) begin
                    failNow("rsp_unexpected");
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    checkOutput("rsp_cycle", cyc, r.at);
                    checkOutput("rsp_err", {30'd0, rsp_err}, {30'd0, r.err});
                    if (r.chk_data) checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, r.data});
                    held_data = r.data;
                    held_err  = r.err;
                    held_chk  = r.chk_data;
                end
                checkOutput("bytes_left_at_rsp", exp_bytes.size(), 0);
                model_busy    = 1'b0;
                last_rsp_data = rsp_data;
                last_rsp_err  = rsp_err;
                rsp_count++;
            end else begin
                checkOutput("rsp_err_hold", {30'd0, rsp_err}, {30'd0, held_err});
                if (held_chk) checkOutput("rsp_data_hold", {24'd0, rsp_data}, {24'd0, held_data});
            end
        end
        prev_tx_start  = tx_start;
        prev_rsp_valid = rsp_valid;
    end

    // Checks every output against its reset value
    task automatic resetChecks(input string tag);
        checkOutput({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        checkOutput({tag, "_busy"},      {31'd0, busy},      32'd0);
        checkOutput({tag, "_tx_start"},  {31'd0, tx_start},  32'd0);
        checkOutput({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
        checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_rsp_data"},  {24'd0, rsp_data},  32'd0);
        checkOutput({tag, "_rsp_err"},   {30'd0, rsp_err},   32'd0);
    endtask

    // Waits for cmd_ready, records the expected byte stream, and hands over a command
    task automatic acceptCmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data,
                             output bit ok);
        int   n;
        rsp_t r;
        n  = 0;
        ok = 1'b0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            failNow("cmd_ready_wait");
            return;
        end
        if (op <= OP_RELEASE_RST) begin
            exp_bytes.push_back(op);
            if (op == OP_WRITE || op == OP_READ) begin
                exp_bytes.push_back(addr[15:8]);
                exp_bytes.push_back(addr[7:0]);
            end
            if (op == OP_WRITE) exp_bytes.push_back(data);
        end else begin
            r.data = 8'h00; r.err = ERR_ILLEGAL_OP; r.at = cyc + 1; r.chk_data = 1'b0;
            exp_rsp.push_back(r);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = ~op;
        cmd_addr   = ~addr;
        cmd_data   = ~data;
        ok = 1'b1;
    endtask

    // Runs one full command: accept, optional stray byte, responder reply or silence
    task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data,
                                 input bit reply_en, input logic [7:0] reply, input bit stray);
        int   n;
        bit   ok;
        rsp_t r;
        acceptCmd(op, addr, data, ok);
        if (!ok) return;
        if (stray) begin
            repeat (3) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        if (op <= OP_RELEASE_RST) begin
            n = 0;
            while (exp_bytes.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            while (!tx_done && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) begin
                failNow("tx_sequence_wait");
                return;
            end
            if (reply_en) begin
                repeat (2) @(negedge clk);
                r.at = cyc + 1;
                r.chk_data = 1'b1;
                r.data = reply;
                if (op == OP_READ || reply == ACK_OK) r.err = ERR_OK;
                else r.err = ERR_BAD_ACK;
                exp_rsp.push_back(r);
                rx_valid = 1'b1;
                rx_data  = reply;
                @(negedge clk);
                rx_valid = 1'b0;
            end else begin
                r.at = last_rise + 1 + TO;
                r.data = 8'h00;
                r.err = ERR_TIMEOUT;
                r.chk_data = 1'b1;
                exp_rsp.push_back(r);
            end
        end
        n = 0;
        while (model_busy && n < TO + 200) begin
            @(negedge clk);
            n++;
        end
        if (model_busy) failNow("rsp_wait");
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  base;
        int  cnt0;
        bit  ok;
        int  n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 8'h00;
        cmd_addr  = 16'h0000;
        cmd_data  = 8'h00;
        tx_done   = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (2) @(negedge clk);
        resetChecks("reset");
        rst = 1'b0;

        $display("[TB] PING with ack 0x00");
        base = sent_log.size();
        applyStimulus(OP_PING, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0);
        checkOutput("ping_count", sent_log.size() - base, 1);
        checkOutput("ping_byte", {24'd0, sent_log[base]}, 32'h05);
        checkOutput("ping_rsp_err", {30'd0, last_rsp_err}, 32'd0);
        checkOutput("ping_rsp_data", {24'd0, last_rsp_data}, 32'h00);

        $display("[TB] WRITE 0x1234 <- 0xAB");
        base = sent_log.size();
        applyStimulus(OP_WRITE, 16'h1234, 8'hAB, 1'b1, 8'h00, 1'b0);
        checkOutput("write_count", sent_log.size() - base, 4);
        checkOutput("write_b0", {24'd0, sent_log[base]},     32'h02);
        checkOutput("write_b1", {24'd0, sent_log[base + 1]}, 32'h12);
        checkOutput("write_b2", {24'd0, sent_log[base + 2]}, 32'h34);
        checkOutput("write_b3", {24'd0, sent_log[base + 3]}, 32'hAB);
        checkOutput("write_rsp_err", {30'd0, last_rsp_err}, 32'd0);

        $display("[TB] READ 0xC0DE reply 0x5A with stray rx byte");
        base = sent_log.size();
        cnt0 = rsp_count;
        applyStimulus(OP_READ, 16'hC0DE, 8'h00, 1'b1, 8'h5A, 1'b1);
        checkOutput("read_count", sent_log.size() - base, 3);
        checkOutput("read_b1", {24'd0, sent_log[base + 1]}, 32'hC0);
        checkOutput("read_b2", {24'd0, sent_log[base + 2]}, 32'hDE);
        checkOutput("read_rsp_data", {24'd0, last_rsp_data}, 32'h5A);
        checkOutput("read_rsp_err", {30'd0, last_rsp_err}, 32'd0);
        checkOutput("read_rsp_strobes", rsp_count - cnt0, 1);

        $display("[TB] HALT answered with 0x7F");
        applyStimulus(OP_HALT, 16'h0000, 8'h00, 1'b1, 8'h7F, 1'b0);
        checkOutput("halt_rsp_err", {30'd0, last_rsp_err}, 32'd1);
        checkOutput("halt_rsp_data", {24'd0, last_rsp_data}, 32'h7F);

        $display("[TB] READ 0xFFFF reply 0xFF");
        applyStimulus(OP_READ, 16'hFFFF, 8'h00, 1'b1, 8'hFF, 1'b0);
        checkOutput("readff_rsp_data", {24'd0, last_rsp_data}, 32'hFF);
        checkOutput("readff_rsp_err", {30'd0, last_rsp_err}, 32'd0);

        $display("[TB] illegal opcode 0x09");
        base = sent_log.size();
        applyStimulus(8'h09, 16'h5555, 8'h55, 1'b0, 8'h00, 1'b0);
        checkOutput("illegal_count", sent_log.size() - base, 0);
        checkOutput("illegal_rsp_err", {30'd0, last_rsp_err}, 32'd3);

`ifdef SYS_CTRL_HOST_TIMEOUT_EN
        $display("[TB] RESET with no reply, then late ack");
        applyStimulus(OP_RESET, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("timeout_rsp_err", {30'd0, last_rsp_err}, 32'd2);
        checkOutput("timeout_rsp_data", {24'd0, last_rsp_data}, 32'h00);
        cnt0 = rsp_count;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("late_ack_dropped", rsp_count - cnt0, 0);
`endif

        $display("[TB] reset during WRITE after second byte");
        acceptCmd(OP_WRITE, 16'hBEEF, 8'h42, ok);
        if (ok) begin
            n = 0;
            while (exp_bytes.size() > 2 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (exp_bytes.size() > 2) failNow("second_byte_wait");
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            exp_bytes.delete();
            exp_rsp.delete();
            model_busy = 1'b0;
            held_data  = 8'h00;
            held_err   = 2'd0;
            held_chk   = 1'b1;
            @(negedge clk);
            resetChecks("midrst");
            rst = 1'b0;
        end

        $display("[TB] PING after mid-command reset");
        cnt0 = rsp_count;
        base = sent_log.size();
        applyStimulus(OP_PING, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0);
        checkOutput("ping2_strobes", rsp_count - cnt0, 1);
        checkOutput("ping2_byte", {24'd0, sent_log[sent_log.size() - 1]}, 32'h05);
        checkOutput("ping2_rsp_err", {30'd0, last_rsp_err}, 32'd0);

        $display("[TB] HOLD_RST with ack 0x00");
        applyStimulus(OP_HOLD_RST, 16'h0000, 8'h00, 1'b1, 8'h00, 1'b0);
        checkOutput("hold_rsp_err", {30'd0, last_rsp_err}, 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
